// File: rtl/mean_stream.sv
// rtl/mean_stream.sv - signed streaming mean, block or moving-average, AXI-Stream in/out
module mean_stream #(
   parameter int DATA_W = 16,
   parameter int LOG2_N = 11,
   parameter int ROUND  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_mode,
   input  logic              clear,
   input  logic              s_axis_data_tvalid,
   output logic              s_axis_data_tready,
   input  logic [DATA_W-1:0] s_axis_data_tdata,
   output logic              m_axis_data_tvalid,
   input  logic              m_axis_data_tready,
   output logic [DATA_W-1:0] m_axis_data_tdata,
   output logic              window_full
);

   localparam int N     = 1 << LOG2_N;
   localparam int ACC_W = DATA_W + LOG2_N + 1;

   localparam logic [LOG2_N-1:0] PTR_ONE  = 1;
   localparam logic [LOG2_N-1:0] PTR_LAST = '1;
   localparam logic signed [ACC_W-1:0] RND =
      (ROUND != 0) ? ACC_W'(1 << (LOG2_N - 1)) : '0;

   // ptr_q is the sample count in block mode and the window write pointer
   // in moving mode; cfg_mode only changes under clear, so one register serves both.
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [LOG2_N-1:0]       ptr_q, ptr_d;
   logic                    full_q, full_d;
   logic                    tvalid_q, tvalid_d;
   logic [DATA_W-1:0]       tdata_q, tdata_d;

   logic [DATA_W-1:0]       ram_q [N];

   logic                    accept;
   logic                    load;
   logic signed [ACC_W-1:0] x_ext;
   logic signed [ACC_W-1:0] old_ext;
   logic signed [ACC_W-1:0] sum;
   logic signed [ACC_W-1:0] rounded;

   assign s_axis_data_tready = !clear && !rst && (!tvalid_q || m_axis_data_tready);
   assign accept             = s_axis_data_tvalid && s_axis_data_tready;
   assign m_axis_data_tvalid = tvalid_q;
   assign m_axis_data_tdata  = tdata_q;
   assign window_full        = full_q;

   assign x_ext   = {{(LOG2_N + 1){s_axis_data_tdata[DATA_W-1]}}, s_axis_data_tdata};
   assign old_ext = full_q ? {{(LOG2_N + 1){ram_q[ptr_q][DATA_W-1]}}, ram_q[ptr_q]} : '0;

   // Next-state: accumulate, decide whether a result is produced, manage the output register.
   always_comb begin
      acc_d    = acc_q;
      ptr_d    = ptr_q;
      full_d   = full_q;
      tvalid_d = tvalid_q;
      tdata_d  = tdata_q;
      load     = 1'b0;
      sum      = acc_q + x_ext;
      rounded  = '0;

      if (accept) begin
         if (!cfg_mode) begin
            sum = acc_q + x_ext;
            if (ptr_q == PTR_LAST) begin
               acc_d = '0;
               ptr_d = '0;
               load  = 1'b1;
            end else begin
               acc_d = sum;
               ptr_d = ptr_q + PTR_ONE;
            end
         end else begin
            sum   = acc_q + x_ext - old_ext;
            acc_d = sum;
            ptr_d = ptr_q + PTR_ONE;
            if (ptr_q == PTR_LAST) begin
               full_d = 1'b1;
            end
            load = full_d;
         end
      end

      rounded = sum + RND;

      if (load) begin
         tvalid_d = 1'b1;
         tdata_d  = DATA_W'(rounded >>> LOG2_N);
      end else if (tvalid_q && m_axis_data_tready) begin
         tvalid_d = 1'b0;
      end

      if (clear) begin
         acc_d    = '0;
         ptr_d    = '0;
         full_d   = 1'b0;
         tvalid_d = 1'b0;
         tdata_d  = tdata_q;
      end
   end

   // State registers; async reset drops any pending result immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q    <= '0;
         ptr_q    <= '0;
         full_q   <= 1'b0;
         tvalid_q <= 1'b0;
         tdata_q  <= '0;
      end else begin
         acc_q    <= acc_d;
         ptr_q    <= ptr_d;
         full_q   <= full_d;
         tvalid_q <= tvalid_d;
         tdata_q  <= tdata_d;
      end
   end

   // Window storage for moving mode; contents are meaningless until the window fills.
   always_ff @(posedge clk) begin
      if (accept && cfg_mode) begin
         ram_q[ptr_q] <= s_axis_data_tdata;
      end
   end

endmodule

// File: tb/tb_mean_stream.sv
// tb/tb_mean_stream.sv - scoreboard bench for mean_stream (block, rounding, moving, stall, clear, reset)
module tb_mean_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        cfg_mode [3];
   logic        clear    [3];
   logic        s_valid  [3];
   logic        s_ready  [3];
   logic [15:0] s_data   [3];
   logic        m_valid  [3];
   logic        m_ready  [3];
   logic [15:0] m_data   [3];
   logic        wfull    [3];
   logic        mode_prev [3];

   logic [15:0] exp_q0 [$];
   logic [15:0] exp_q1 [$];
   logic [15:0] exp_q2 [$];

   int n_checks = 0;
   int n_pass   = 0;

   // u0: block N=8 truncate, u1: block N=8 round, u2: moving N=4 truncate
   mean_stream #(.DATA_W(16), .LOG2_N(3), .ROUND(0)) u0 (
      .clk(clk), .rst(rst), .cfg_mode(cfg_mode[0]), .clear(clear[0]),
      .s_axis_data_tvalid(s_valid[0]), .s_axis_data_tready(s_ready[0]), .s_axis_data_tdata(s_data[0]),
      .m_axis_data_tvalid(m_valid[0]), .m_axis_data_tready(m_ready[0]), .m_axis_data_tdata(m_data[0]),
      .window_full(wfull[0]));

   mean_stream #(.DATA_W(16), .LOG2_N(3), .ROUND(1)) u1 (
      .clk(clk), .rst(rst), .cfg_mode(cfg_mode[1]), .clear(clear[1]),
      .s_axis_data_tvalid(s_valid[1]), .s_axis_data_tready(s_ready[1]), .s_axis_data_tdata(s_data[1]),
      .m_axis_data_tvalid(m_valid[1]), .m_axis_data_tready(m_ready[1]), .m_axis_data_tdata(m_data[1]),
      .window_full(wfull[1]));

   mean_stream #(.DATA_W(16), .LOG2_N(2), .ROUND(0)) u2 (
      .clk(clk), .rst(rst), .cfg_mode(cfg_mode[2]), .clear(clear[2]),
      .s_axis_data_tvalid(s_valid[2]), .s_axis_data_tready(s_ready[2]), .s_axis_data_tdata(s_data[2]),
      .m_axis_data_tvalid(m_valid[2]), .m_axis_data_tready(m_ready[2]), .m_axis_data_tdata(m_data[2]),
      .window_full(wfull[2]));

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic fail_note(input string name);
      n_checks++;
      $display("FAIL %s", name);
   endtask

   // Monitor: every output transfer pops and compares against the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         if (m_valid[0] && m_ready[0]) begin
            if (exp_q0.size() == 0) fail_note("u0 unexpected output");
            else chk("u0 out", m_data[0], exp_q0.pop_front());
         end
         if (m_valid[1] && m_ready[1]) begin
            if (exp_q1.size() == 0) fail_note("u1 unexpected output");
            else chk("u1 out", m_data[1], exp_q1.pop_front());
         end
         if (m_valid[2] && m_ready[2]) begin
            if (exp_q2.size() == 0) fail_note("u2 unexpected output");
            else chk("u2 out", m_data[2], exp_q2.pop_front());
         end
      end
   end

   // Bench protocol: cfg_mode may only move while clear is high.
   always @(posedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (!rst && cfg_mode[d] !== mode_prev[d] && !clear[d]) fail_note("cfg_mode changed without clear");
         mode_prev[d] <= cfg_mode[d];
      end
   end

   task automatic send(input int d, input logic [15:0] x);
      int t;
      s_valid[d] = 1'b1;
      s_data[d]  = x;
      t = 0;
      #0;
      while (!s_ready[d] && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 200) fail_note("send timeout");
      else begin
         @(posedge clk); #1;
      end
      s_valid[d] = 1'b0;
   endtask

   task automatic send_rep(input int d, input logic [15:0] x, input int n);
      for (int i = 0; i < n; i++) send(d, x);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((exp_q0.size() + exp_q1.size() + exp_q2.size()) != 0 && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 200) fail_note("drain timeout");
   endtask

   initial begin
      rst = 1'b1;
      for (int d = 0; d < 3; d++) begin
         cfg_mode[d]  = (d == 2);
         mode_prev[d] = (d == 2);
         clear[d]     = 1'b0;
         s_valid[d]   = 1'b0;
         s_data[d]    = 16'h0;
         m_ready[d]   = 1'b1;
      end
      #1;
      chk("reset tvalid", {15'b0, m_valid[0]}, 16'h0);
      chk("reset tdata", m_data[0], 16'h0);
      chk("reset tready", {15'b0, s_ready[0]}, 16'h0);
      chk("reset window_full", {15'b0, wfull[2]}, 16'h0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("tready after reset", {15'b0, s_ready[0]}, 16'h1);

      // 1..8: sum 36 -> floor 4, rounded 5
      exp_q0.push_back(16'd4);
      for (int i = 1; i <= 8; i++) begin
         send(0, 16'(i));
         if (i == 7) chk("no early output", {15'b0, m_valid[0]}, 16'h0);
      end
      chk("latency valid", {15'b0, m_valid[0]}, 16'h1);
      exp_q1.push_back(16'd5);
      for (int i = 1; i <= 8; i++) send(1, 16'(i));

      // sum -1 -> floor -1, rounded 0
      exp_q0.push_back(16'hFFFF);
      exp_q1.push_back(16'h0000);
      send_rep(0, 16'h0, 7); send(0, 16'hFFFF);
      send_rep(1, 16'h0, 7); send(1, 16'hFFFF);

      // most negative input, no overflow
      exp_q0.push_back(16'h8000);
      exp_q1.push_back(16'h8000);
      send_rep(0, 16'h8000, 8);
      send_rep(1, 16'h8000, 8);
      drain();

      // backpressure: result held, input blocked
      m_ready[0] = 1'b0;
      for (int i = 1; i <= 8; i++) send(0, 16'(i));
      s_valid[0] = 1'b1;
      s_data[0]  = 16'd2;
      repeat (3) begin @(posedge clk); #1; end
      chk("stall tvalid", {15'b0, m_valid[0]}, 16'h1);
      chk("stall tdata", m_data[0], 16'd4);
      chk("stall tready", {15'b0, s_ready[0]}, 16'h0);
      exp_q0.push_back(16'd4);
      exp_q0.push_back(16'd2);
      m_ready[0] = 1'b1;
      send_rep(0, 16'd2, 8);
      drain();

      // moving N=4: 4,8,12,16,20,24 -> 10,14,18
      exp_q2.push_back(16'd10);
      exp_q2.push_back(16'd14);
      exp_q2.push_back(16'd18);
      send(2, 16'd4); send(2, 16'd8); send(2, 16'd12);
      chk("moving not full", {15'b0, wfull[2]}, 16'h0);
      chk("moving no output", {15'b0, m_valid[2]}, 16'h0);
      send(2, 16'd16);
      chk("moving full", {15'b0, wfull[2]}, 16'h1);
      chk("moving valid 1", {15'b0, m_valid[2]}, 16'h1);
      send(2, 16'd20);
      chk("moving valid 2", {15'b0, m_valid[2]}, 16'h1);
      send(2, 16'd24);
      chk("moving valid 3", {15'b0, m_valid[2]}, 16'h1);
      chk("block window_full", {15'b0, wfull[0]}, 16'h0);
      drain();

      // clear mid-block discards partial sum and blocks input
      send_rep(0, 16'd100, 3);
      clear[0]   = 1'b1;
      s_valid[0] = 1'b1;
      s_data[0]  = 16'd100;
      #1;
      chk("clear tready", {15'b0, s_ready[0]}, 16'h0);
      @(posedge clk); #1;
      clear[0]   = 1'b0;
      s_valid[0] = 1'b0;
      exp_q0.push_back(16'd2);
      send_rep(0, 16'd2, 8);
      drain();

      // async reset while stalled
      m_ready[0] = 1'b0;
      for (int i = 1; i <= 8; i++) send(0, 16'(i));
      chk("pre-rst tvalid", {15'b0, m_valid[0]}, 16'h1);
      chk("pre-rst window_full", {15'b0, wfull[2]}, 16'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("rst tvalid", {15'b0, m_valid[0]}, 16'h0);
      chk("rst tdata", m_data[0], 16'h0);
      chk("rst window_full", {15'b0, wfull[2]}, 16'h0);
      chk("rst tready", {15'b0, s_ready[0]}, 16'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      m_ready[0] = 1'b1;
      exp_q0.push_back(16'd7);
      send_rep(0, 16'd7, 8);
      drain();
      repeat (3) @(posedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
